// File: rtl/sram_arbiter.sv
// Two-master Wishbone arbiter in front of the single SPI SRAM bridge.
// Round-robin grant held for the whole cycle, one idle gap between grants, optional ack timeout.
module sram_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [22:0] m0_adr_i,
  input  logic [7:0]  m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [22:0] m1_adr_i,
  input  logic [7:0]  m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [7:0]  m_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [22:0] s_adr_o,
  output logic [7:0]  s_dat_o,
  input  logic        s_ack_i,
  input  logic [7:0]  s_dat_i
);

  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic          grant_reg, grant_next;
  logic          last_reg, last_next;
  logic [CW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [1:0]    err_reg, err_next;

  logic [1:0] cyc_v, stb_v, req_v, ack_v;
  logic       busy;
  logic       g_cyc, g_stb, g_we;
  logic [22:0] g_adr;
  logic [7:0]  g_dat;

  assign cyc_v = {m1_cyc_i, m0_cyc_i};
  assign stb_v = {m1_stb_i, m0_stb_i};

  // Bus is only driven in BUSY, and never while reset is held.
  assign busy = (state_reg == BUSY) && !rst_i;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
      assign req_v[gi] = cyc_v[gi] & stb_v[gi];
      assign ack_v[gi] = busy && (grant_reg == 1'(gi)) && s_ack_i;
    end
  endgenerate

  assign g_cyc = grant_reg ? m1_cyc_i : m0_cyc_i;
  assign g_stb = grant_reg ? m1_stb_i : m0_stb_i;
  assign g_we  = grant_reg ? m1_we_i  : m0_we_i;
  assign g_adr = grant_reg ? m1_adr_i : m0_adr_i;
  assign g_dat = grant_reg ? m1_dat_i : m0_dat_i;

  assign s_cyc_o = busy & g_cyc;
  assign s_stb_o = busy & g_stb;
  assign s_we_o  = busy & g_we;
  assign s_adr_o = busy ? g_adr : '0;
  assign s_dat_o = busy ? g_dat : '0;
  assign m_dat_o = s_dat_i;

  assign m0_ack_o = ack_v[0];
  assign m1_ack_o = ack_v[1];
  assign m0_err_o = err_reg[0];
  assign m1_err_o = err_reg[1];

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    last_next    = last_reg;
    tmo_cnt_next = tmo_cnt_reg;
    err_next     = '0;
    case (state_reg)
      IDLE: begin
        if (req_v[0] || req_v[1]) begin
          // On a tie the master that did not win last time goes first.
          grant_next   = (req_v[0] && req_v[1]) ? ~last_reg : req_v[1];
          last_next    = grant_next;
          tmo_cnt_next = '0;
          state_next   = BUSY;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          tmo_cnt_next = '0;
          state_next   = GAP;
        end else if (g_stb && !s_ack_i && (TIMEOUT > 0)) begin
          if (tmo_cnt_reg == TMO_LAST) begin
            err_next[grant_reg] = 1'b1;
            tmo_cnt_next        = '0;
            state_next          = GAP;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
          end
        end else begin
          tmo_cnt_next = '0;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      grant_reg   <= 1'b0;
      last_reg    <= 1'b1;
      tmo_cnt_reg <= '0;
      err_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      last_reg    <= last_next;
      tmo_cnt_reg <= tmo_cnt_next;
      err_reg     <= err_next;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a default-timeout instance and a TIMEOUT=8 instance share stimulus;
// ack/err events are checked against a scoreboard queue filled as the bridge responses are driven.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [22:0] m0_adr, m1_adr;
  logic [7:0]  m0_dat, m1_dat;
  logic        s_ack;
  logic [7:0]  s_dat;

  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_cyc, a_s_stb, a_s_we;
  logic [7:0]  a_m_dat, a_s_dat;
  logic [22:0] a_s_adr;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_cyc, b_s_stb, b_s_we;
  logic [7:0]  b_m_dat, b_s_dat;
  logic [22:0] b_s_adr;

  int total = 0;
  int bad = 0;
  bit use_a = 1'b0;

  typedef struct packed {
    logic       m1e;
    logic       m0e;
    logic       m1a;
    logic       m0a;
    logic [7:0] dat;
  } ev_t;

  ev_t sb[$];
  ev_t obs;
  ev_t exp_ev;

  always #5 clk = ~clk;

  sram_arbiter u_a (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
    .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
    .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
    .m_dat_o(a_m_dat),
    .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_adr_o(a_s_adr), .s_dat_o(a_s_dat),
    .s_ack_i(s_ack), .s_dat_i(s_dat)
  );

  sram_arbiter #(.TIMEOUT(8)) u_b (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
    .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
    .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
    .m_dat_o(b_m_dat),
    .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_adr_o(b_s_adr), .s_dat_o(b_s_dat),
    .s_ack_i(s_ack), .s_dat_i(s_dat)
  );

  assign obs = use_a ? {a_m1_err, a_m0_err, a_m1_ack, a_m0_ack, a_m_dat}
                     : {b_m1_err, b_m0_err, b_m1_ack, b_m0_ack, b_m_dat};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  // Every ack/err seen on the monitored instance must match the next expected event.
  always @(negedge clk) begin
    if (obs.m1e || obs.m0e || obs.m1a || obs.m0a) begin
      if (sb.size() == 0) begin
        chk("sb_extra", 32'(obs), 32'h0);
      end else begin
        exp_ev = sb.pop_front();
        chk("sb_evt", 32'(obs), 32'(exp_ev));
        $display("txn m%0d %s dat=%02h", (obs.m1a | obs.m1e), (obs.m0e | obs.m1e) ? "err" : "ack", obs.dat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int idx, input logic we, input logic [22:0] adr, input logic [7:0] dat);
    if (idx == 0) begin
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = we; m0_adr = adr; m0_dat = dat;
    end else begin
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = we; m1_adr = adr; m1_dat = dat;
    end
  endtask

  task automatic drop(input int idx);
    if (idx == 0) begin
      m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_dat = '0;
    end else begin
      m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_dat = '0;
    end
  endtask

  // One bridge ack beat carrying rdat, expected at master idx.
  task automatic serve(input int idx, input logic [7:0] rdat);
    ev_t e;
    e = '0;
    e.dat = rdat;
    if (idx == 0) e.m0a = 1'b1;
    else e.m1a = 1'b1;
    sb.push_back(e);
    s_dat = rdat;
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    s_dat = '0;
  endtask

  task automatic push_err(input int idx);
    ev_t e;
    e = '0;
    if (idx == 0) e.m0e = 1'b1;
    else e.m1e = 1'b1;
    sb.push_back(e);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drop(0);
    drop(1);
    s_ack = 1'b0;
    s_dat = '0;

    // Reset while a master requests and the bridge acks: bus stays quiet.
    req(0, 1'b1, 23'h1, 8'h0);
    s_ack = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_scyc", b_s_cyc, 0);
    chk("rst_ack0", b_m0_ack, 0);
    chk("rst_adr", b_s_adr, 0);
    chk("rst_err0", b_m0_err, 0);
    chk("rst_err1", b_m1_err, 0);
    chk("rst_scyc_a", a_s_cyc, 0);
    drop(0);
    s_ack = 1'b0;

    // Master 0 alone writes, bridge acks after 40 cycles (default timeout instance).
    use_a = 1'b1;
    reset_dut();
    req(0, 1'b1, 23'h012345, 8'hA5);
    #1 chk("t1_idle", a_s_cyc, 0);
    tick();
    #1;
    chk("t1_cyc", a_s_cyc, 1);
    chk("t1_adr", a_s_adr, 23'h012345);
    chk("t1_we", a_s_we, 1);
    chk("t1_dat", a_s_dat, 8'hA5);
    repeat (39) tick();
    chk("t1_noack", a_m0_ack, 0);
    chk("t1_stillcyc", a_s_cyc, 1);
    sb.push_back(ev_t'{m1e: 1'b0, m0e: 1'b0, m1a: 1'b0, m0a: 1'b1, dat: 8'h00});
    s_ack = 1'b1;
    #1;
    chk("t1_ack0", a_m0_ack, 1);
    chk("t1_ack1", a_m1_ack, 0);
    tick();
    s_ack = 1'b0;
    drop(0);
    tick();
    #1 chk("t1_gap", a_s_cyc, 0);
    tick();

    // Simultaneous requests after reset: m0, gap, m1, then alternation.
    use_a = 1'b0;
    reset_dut();
    req(0, 1'b1, 23'h10, 8'h10);
    req(1, 1'b0, 23'h20, 8'h00);
    tick();
    #1;
    chk("t2_g0cyc", b_s_cyc, 1);
    chk("t2_g0adr", b_s_adr, 23'h10);
    serve(0, 8'h00);
    drop(0);
    tick();
    #1 chk("t2_gap", b_s_cyc, 0);
    tick();
    #1 chk("t2_idle", b_s_cyc, 0);
    tick();
    #1;
    chk("t2_g1cyc", b_s_cyc, 1);
    chk("t2_g1adr", b_s_adr, 23'h20);
    chk("t2_g1we", b_s_we, 0);
    serve(1, 8'h5A);
    drop(1);
    tick();
    tick();
    req(0, 1'b1, 23'h30, 8'h31);
    req(1, 1'b0, 23'h40, 8'h00);
    tick();
    #1 chk("t2_alt0", b_s_adr, 23'h30);
    serve(0, 8'h00);
    drop(0);
    tick();
    tick();
    tick();
    #1 chk("t2_alt1", b_s_adr, 23'h40);
    serve(1, 8'h66);
    drop(1);
    tick();
    tick();

    // m1 holds the grant across three read beats while m0 waits.
    reset_dut();
    req(1, 1'b0, 23'h100, 8'h00);
    tick();
    req(0, 1'b1, 23'h200, 8'h77);
    #1 chk("t3_hold", b_s_adr, 23'h100);
    serve(1, 8'h11);
    serve(1, 8'h22);
    serve(1, 8'h33);
    #1 chk("t3_keep", b_s_adr, 23'h100);
    drop(1);
    tick();
    #1 chk("t3_gap", b_s_cyc, 0);
    tick();
    tick();
    #1;
    chk("t3_g0adr", b_s_adr, 23'h200);
    chk("t3_g0dat", b_s_dat, 8'h77);
    serve(0, 8'h00);
    drop(0);
    tick();
    tick();

    // Timeout: bridge never acks m0; m0 keeps cyc, m1 pending.
    reset_dut();
    req(0, 1'b1, 23'h7, 8'h01);
    tick();
    req(1, 1'b0, 23'h9, 8'h00);
    repeat (7) tick();
    chk("t4_pre_err", b_m0_err, 0);
    chk("t4_pre_cyc", b_s_cyc, 1);
    push_err(0);
    tick();
    #1;
    chk("t4_err", b_m0_err, 1);
    chk("t4_err_cyc", b_s_cyc, 0);
    chk("t4_err_m1", b_m1_err, 0);
    tick();
    #1;
    chk("t4_err_once", b_m0_err, 0);
    chk("t4_idle", b_s_cyc, 0);
    tick();
    #1;
    chk("t4_m1cyc", b_s_cyc, 1);
    chk("t4_m1adr", b_s_adr, 23'h9);
    drop(0);
    serve(1, 8'h3C);
    drop(1);
    tick();
    tick();

    // Ack arriving in the last allowed cycle wins over the timeout.
    reset_dut();
    req(0, 1'b1, 23'h55, 8'h02);
    tick();
    repeat (7) tick();
    serve(0, 8'h00);
    #1;
    chk("t5_noerr", b_m0_err, 0);
    chk("t5_busy", b_s_cyc, 1);
    drop(0);
    tick();
    tick();

    // Reset in the middle of an m1 transfer.
    reset_dut();
    req(1, 1'b0, 23'h300, 8'h00);
    tick();
    #1 chk("t6_busy", b_s_cyc, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_ack = 1'b1;
    #1;
    chk("t6_rcyc", b_s_cyc, 0);
    chk("t6_rack1", b_m1_ack, 0);
    chk("t6_rack0", b_m0_ack, 0);
    chk("t6_rerr1", b_m1_err, 0);
    s_ack = 1'b0;
    req(0, 1'b1, 23'h400, 8'h09);
    tick();
    #1 chk("t6_g0", b_s_adr, 23'h400);
    serve(0, 8'h00);
    drop(0);
    drop(1);
    tick();
    tick();

    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
